// File: rtl/pc_alu_unit_if.sv
// -----------------------------------------------------------------------------
// pc_alu_unit_if
// Purpose : groups the execute-stage signals exchanged between the main control /
//           register file side (master) and the pc_alu_unit core (slave).
// Signals :
//   branch   master->slave  beq request from main control
//   imm16    master->slave  instruction[15:0], signed branch offset in words
//   alu_op   master->slave  ALU opcode from main control
//   funct    master->slave  instruction[5:0]
//   shamt    master->slave  instruction[10:6]
//   oper1    master->slave  ALU operand A (rs data)
//   oper2    master->slave  ALU operand B (rt data or immediate)
//   pc       slave->master  current instruction byte address
//   alu_cmd  slave->master  decoded ALU command
//   result   slave->master  ALU result
//   overflow slave->master  signed overflow flag (informational)
//   zero     slave->master  high when result is zero
// -----------------------------------------------------------------------------
interface pc_alu_unit_if;
   logic        branch;
   logic [15:0] imm16;
   logic [3:0]  alu_op;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [31:0] oper1;
   logic [31:0] oper2;
   logic [7:0]  pc;
   logic [3:0]  alu_cmd;
   logic [31:0] result;
   logic        overflow;
   logic        zero;

   modport master (
      output branch, imm16, alu_op, funct, shamt, oper1, oper2,
      input  pc, alu_cmd, result, overflow, zero
   );

   modport slave (
      input  branch, imm16, alu_op, funct, shamt, oper1, oper2,
      output pc, alu_cmd, result, overflow, zero
   );
endinterface

// File: rtl/pc_alu_unit.sv
// -----------------------------------------------------------------------------
// pc_alu_unit
// Purpose : execute-stage core of a single-cycle MIPS-style CPU. Holds the 8-bit
//           program counter, decodes the ALU command from alu_op/funct and
//           performs the 32-bit ALU operation. The zero flag drives the beq
//           decision for the next PC.
// Ports   :
//   clk_i   rising-edge clock
//   clr_i   synchronous active-high reset (pc only)
//   bus_io  pc_alu_unit_if.slave : control/operand inputs, pc/ALU outputs
// Notes   : alu_cmd/result/overflow/zero are combinational; only pc is state.
// -----------------------------------------------------------------------------
module pc_alu_unit (
   input  logic         clk_i,
   input  logic         clr_i,
   pc_alu_unit_if.slave bus_io
);

   typedef enum logic [3:0] {
      CMD_AND = 4'b0000,
      CMD_OR  = 4'b0001,
      CMD_ADD = 4'b0010,
      CMD_XOR = 4'b0011,
      CMD_SLL = 4'b0100,
      CMD_SRL = 4'b0101,
      CMD_SUB = 4'b0110,
      CMD_SLT = 4'b0111,
      CMD_NOR = 4'b1100
   } alu_cmd_e;

   // R-type funct field to ALU command; unknown functs fall back to ADD.
   function automatic alu_cmd_e decode_funct(input logic [5:0] funct);
      alu_cmd_e cmd;
      case (funct)
         6'b100000: cmd = CMD_ADD;
         6'b100010: cmd = CMD_SUB;
         6'b100100: cmd = CMD_AND;
         6'b100101: cmd = CMD_OR;
         6'b100110: cmd = CMD_XOR;
         6'b100111: cmd = CMD_NOR;
         6'b101010: cmd = CMD_SLT;
         6'b000000: cmd = CMD_SLL;
         6'b000010: cmd = CMD_SRL;
         default:   cmd = CMD_ADD;
      endcase
      return cmd;
   endfunction

   alu_cmd_e    alu_cmd_s;
   logic [31:0] sum_s;
   logic [31:0] diff_s;
   logic [31:0] result_s;
   logic        overflow_s;
   logic        zero_s;
   logic [7:0]  pc_q;
   logic [7:0]  pc_d;
   logic [7:0]  pc_seq_s;
   logic [7:0]  pc_branch_s;

   // ALU command decode from main-control opcode (R-type defers to funct).
   always_comb begin
      alu_cmd_s = CMD_ADD;
      case (bus_io.alu_op)
         4'b0000: alu_cmd_s = CMD_ADD;
         4'b0001: alu_cmd_s = CMD_SUB;
         4'b0010: alu_cmd_s = decode_funct(bus_io.funct);
         4'b0011: alu_cmd_s = CMD_AND;
         4'b0100: alu_cmd_s = CMD_OR;
         4'b0101: alu_cmd_s = CMD_XOR;
         4'b0110: alu_cmd_s = CMD_SLT;
         default: alu_cmd_s = CMD_ADD;
      endcase
   end

   assign sum_s  = bus_io.oper1 + bus_io.oper2;
   assign diff_s = bus_io.oper1 - bus_io.oper2;

   // ALU datapath and signed overflow detection.
   always_comb begin
      result_s   = 32'h0000_0000;
      overflow_s = 1'b0;
      case (alu_cmd_s)
         CMD_AND: result_s = bus_io.oper1 & bus_io.oper2;
         CMD_OR:  result_s = bus_io.oper1 | bus_io.oper2;
         CMD_ADD: begin
            result_s   = sum_s;
            // Same-sign operands producing a different-sign sum.
            overflow_s = (bus_io.oper1[31] == bus_io.oper2[31]) &&
                         (sum_s[31] != bus_io.oper1[31]);
         end
         CMD_XOR: result_s = bus_io.oper1 ^ bus_io.oper2;
         CMD_SLL: result_s = bus_io.oper2 << bus_io.shamt;
         CMD_SRL: result_s = bus_io.oper2 >> bus_io.shamt;
         CMD_SUB: begin
            result_s   = diff_s;
            // Different-sign operands where the difference flips away from oper1.
            overflow_s = (bus_io.oper1[31] != bus_io.oper2[31]) &&
                         (diff_s[31] != bus_io.oper1[31]);
         end
         CMD_SLT: result_s = {31'd0, ($signed(bus_io.oper1) < $signed(bus_io.oper2))};
         CMD_NOR: result_s = ~(bus_io.oper1 | bus_io.oper2);
         default: result_s = 32'h0000_0000;
      endcase
   end

   assign zero_s = (result_s == 32'h0000_0000);

   // Sequential and branch targets. Only the low 8 bits of the shifted,
   // sign-extended offset matter since PC arithmetic is modulo 256.
   assign pc_seq_s    = pc_q + 8'd4;
   assign pc_branch_s = pc_seq_s + 8'({{16{bus_io.imm16[15]}}, bus_io.imm16} << 2);

   // Next-PC selection: taken beq when branch is requested and the ALU result is zero.
   always_comb begin
      pc_d = pc_seq_s;
      if (bus_io.branch && zero_s) begin
         pc_d = pc_branch_s;
      end else begin
         pc_d = pc_seq_s;
      end
   end

   // PC register with synchronous clear that overrides any branch.
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         pc_q <= 8'h00;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign bus_io.pc       = pc_q;
   assign bus_io.alu_cmd  = alu_cmd_s;
   assign bus_io.result   = result_s;
   assign bus_io.overflow = overflow_s;
   assign bus_io.zero     = zero_s;

endmodule

// File: tb/tb_pc_alu_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_alu_unit
// Purpose : directed-vector bench for pc_alu_unit. Each row drives one cycle of
//           inputs and pushes hand-computed expectations (ALU outputs for those
//           inputs, and the pc value produced by the previous edge) into a
//           queue; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_pc_alu_unit;

   logic clk;
   logic clr;

   pc_alu_unit_if bus_if();

   pc_alu_unit dut (
      .clk_i  (clk),
      .clr_i  (clr),
      .bus_io (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [3:0]  cmd;
      logic [31:0] res;
      logic        ov;
      logic        z;
      bit          chk_pc;
      logic [7:0]  pc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus_if.alu_cmd !== e.cmd) begin
               n_fail++;
               $display("FAIL %s.alu_cmd: got %b expected %b", e.name, bus_if.alu_cmd, e.cmd);
            end
            n_checks++;
            if (bus_if.result !== e.res) begin
               n_fail++;
               $display("FAIL %s.result: got %h expected %h", e.name, bus_if.result, e.res);
            end
            n_checks++;
            if (bus_if.overflow !== e.ov) begin
               n_fail++;
               $display("FAIL %s.overflow: got %b expected %b", e.name, bus_if.overflow, e.ov);
            end
            n_checks++;
            if (bus_if.zero !== e.z) begin
               n_fail++;
               $display("FAIL %s.zero: got %b expected %b", e.name, bus_if.zero, e.z);
            end
            if (e.chk_pc) begin
               n_checks++;
               if (bus_if.pc !== e.pc) begin
                  n_fail++;
                  $display("FAIL %s.pc: got %h expected %h", e.name, bus_if.pc, e.pc);
               end
            end
         end
      end
   end

   // One cycle: drive inputs just after the rising edge, queue expectations.
   task automatic row(input string name, input logic c, input logic br,
                      input logic [15:0] imm, input logic [3:0] op,
                      input logic [5:0] fn, input logic [4:0] sh,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] cmd, input logic [31:0] res,
                      input logic ov, input logic z,
                      input bit chk_pc, input logic [7:0] pc);
      exp_t e;
      @(posedge clk);
      #1;
      clr           = c;
      bus_if.branch = br;
      bus_if.imm16  = imm;
      bus_if.alu_op = op;
      bus_if.funct  = fn;
      bus_if.shamt  = sh;
      bus_if.oper1  = a;
      bus_if.oper2  = b;
      e.name   = name;
      e.cmd    = cmd;
      e.res    = res;
      e.ov     = ov;
      e.z      = z;
      e.chk_pc = chk_pc;
      e.pc     = pc;
      exp_q.push_back(e);
   endtask

   initial begin
      clr           = 1'b1;
      bus_if.branch = 1'b0;
      bus_if.imm16  = 16'h0000;
      bus_if.alu_op = 4'b0000;
      bus_if.funct  = 6'b000000;
      bus_if.shamt  = 5'd0;
      bus_if.oper1  = 32'h0;
      bus_if.oper2  = 32'h0;

      //   name        clr   br    imm16      alu_op   funct      sh     oper1         oper2         cmd      result        ov    z     chkpc pc
      row("reset",     1'b1, 1'b0, 16'h0000, 4'b0000, 6'b000000, 5'd0,  32'h0000_0000, 32'h0000_0000, 4'b0010, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 8'h00);
      row("add_ovf",   1'b0, 1'b0, 16'h0000, 4'b0010, 6'b100000, 5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 8'h00);
      row("slt_neg",   1'b0, 1'b0, 16'h0000, 4'b0010, 6'b101010, 5'd0,  32'hFFFF_FFFF, 32'h0000_0001, 4'b0111, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 8'h04);
      row("slt_pos",   1'b0, 1'b0, 16'h0000, 4'b0010, 6'b101010, 5'd0,  32'h0000_0001, 32'hFFFF_FFFF, 4'b0111, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 8'h08);
      row("sll",       1'b0, 1'b0, 16'h0000, 4'b0010, 6'b000000, 5'd4,  32'h0000_0000, 32'h0000_000F, 4'b0100, 32'h0000_00F0, 1'b0, 1'b0, 1'b1, 8'h0C);
      row("beq_back",  1'b0, 1'b1, 16'hFFFE, 4'b0001, 6'b000000, 5'd0,  32'h0000_0005, 32'h0000_0005, 4'b0110, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 8'h10);
      row("srl",       1'b0, 1'b0, 16'h0000, 4'b0010, 6'b000010, 5'd31, 32'h0000_0000, 32'h8000_0000, 4'b0101, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 8'h0C);
      row("nor",       1'b0, 1'b0, 16'h0000, 4'b0010, 6'b100111, 5'd0,  32'h0000_0000, 32'h0000_0000, 4'b1100, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 8'h10);
      row("op_dflt",   1'b0, 1'b0, 16'h0000, 4'b1111, 6'b000000, 5'd0,  32'h0000_0003, 32'h0000_0004, 4'b0010, 32'h0000_0007, 1'b0, 1'b0, 1'b1, 8'h14);
      row("sub_ovf",   1'b0, 1'b1, 16'h0010, 4'b0001, 6'b000000, 5'd0,  32'h8000_0000, 32'h0000_0001, 4'b0110, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 8'h18);
      row("beq_fwd",   1'b0, 1'b1, 16'h0003, 4'b0001, 6'b000000, 5'd0,  32'h0000_0009, 32'h0000_0009, 4'b0110, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 8'h1C);
      row("and",       1'b0, 1'b0, 16'h0000, 4'b0011, 6'b000000, 5'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, 32'hF000_F000, 1'b0, 1'b0, 1'b1, 8'h2C);
      row("or",        1'b0, 1'b0, 16'h0000, 4'b0100, 6'b000000, 5'd0,  32'hF0F0_F0F0, 32'h0F0F_0000, 4'b0001, 32'hFFFF_F0F0, 1'b0, 1'b0, 1'b1, 8'h30);
      row("xor",       1'b0, 1'b0, 16'h0000, 4'b0101, 6'b000000, 5'd0,  32'hFFFF_0000, 32'hFF00_FF00, 4'b0011, 32'h00FF_FF00, 1'b0, 1'b0, 1'b1, 8'h34);
      row("slt_op",    1'b0, 1'b0, 16'h0000, 4'b0110, 6'b000000, 5'd0,  32'h8000_0000, 32'h0000_0000, 4'b0111, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 8'h38);
      row("clr_wins",  1'b1, 1'b1, 16'h0004, 4'b0001, 6'b000000, 5'd0,  32'h0000_0002, 32'h0000_0002, 4'b0110, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 8'h3C);
      row("beq_wrap",  1'b0, 1'b1, 16'h7FFF, 4'b0001, 6'b000000, 5'd0,  32'h0000_0000, 32'h0000_0000, 4'b0110, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 8'h00);
      row("fn_dflt",   1'b0, 1'b0, 16'h0000, 4'b0010, 6'b111111, 5'd0,  32'h0000_000A, 32'h0000_0014, 4'b0010, 32'h0000_001E, 1'b0, 1'b0, 1'b1, 8'h00);
      row("beq_to_fc", 1'b0, 1'b1, 16'hFFFD, 4'b0001, 6'b000000, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b0110, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 8'h04);
      row("add_novf",  1'b0, 1'b0, 16'h0000, 4'b0000, 6'b000000, 5'd0,  32'h8000_0000, 32'h8000_0000, 4'b0010, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 8'hFC);
      row("pc_wrap",   1'b0, 1'b0, 16'h0000, 4'b0000, 6'b000000, 5'd0,  32'h0000_0001, 32'h0000_0001, 4'b0010, 32'h0000_0002, 1'b0, 1'b0, 1'b1, 8'h00);

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
